// File: rtl/fog_mod_gen_ms.sv
// FOG phase-modulation generator: 2- or 4-state stepped levels with shadowed settings.
// Latency: a level is visible from the edge that enters its state; no backpressure.
module fog_mod_gen_ms #(
    parameter int OUTPUT_BIT = 32,
    parameter int SETTLE_BIT = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_mode,
    input  logic [31:0]                  i_freq_cnt,
    input  logic [SETTLE_BIT-1:0]        i_settle,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_0,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_1,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_2,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_3,
    output logic signed [OUTPUT_BIT-1:0] o_mod_out,
    output logic [1:0]                   o_state,
    output logic                         o_status,
    output logic                         o_stepTrig,
    output logic                         o_sample_valid,
    output logic                         o_period_end
);

    typedef enum logic [2:0] {ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3} st_t;

    st_t st_q, st_nxt, prev_q;

    logic [31:0]                  dwell_q;
    logic [SETTLE_BIT-1:0]        elapsed_q;
    logic                         mode_sh;
    logic [31:0]                  freq_sh;
    logic [SETTLE_BIT-1:0]        settle_sh;
    logic signed [OUTPUT_BIT-1:0] amp_sh_1, amp_sh_2, amp_sh_3;

    logic signed [OUTPUT_BIT-1:0] lvl_nxt;
    logic [1:0]                   idx_nxt;
    logic                         step;
    logic                         dwell_done;

    assign dwell_done = (dwell_q == '0);

    always_comb begin
        st_nxt = st_q;
        case (st_q)
            ST_IDLE: st_nxt = ST_S0;
            ST_S0:   if (dwell_done) st_nxt = ST_S1;
            ST_S1:   if (dwell_done) st_nxt = mode_sh ? ST_S2 : ST_S0;
            ST_S2:   if (dwell_done) st_nxt = ST_S3;
            ST_S3:   if (dwell_done) st_nxt = ST_S0;
            default: st_nxt = ST_IDLE;
        endcase
        // Disable overrides any transition due on the same edge.
        if (!i_en) st_nxt = ST_IDLE;
    end

    // S0 takes its level straight from the input because shadows load on that same edge.
    always_comb begin
        lvl_nxt = i_amp_0;
        idx_nxt = 2'd0;
        case (st_nxt)
            ST_S1: begin lvl_nxt = amp_sh_1; idx_nxt = 2'd1; end
            ST_S2: begin lvl_nxt = amp_sh_2; idx_nxt = 2'd2; end
            ST_S3: begin lvl_nxt = amp_sh_3; idx_nxt = 2'd3; end
            default: ;
        endcase
    end

    assign step = (st_nxt != st_q) && (st_nxt != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q       <= ST_IDLE;
            prev_q     <= ST_IDLE;
            o_mod_out  <= '0;
            o_state    <= 2'd0;
            o_stepTrig <= 1'b0;
            dwell_q    <= '0;
            elapsed_q  <= '0;
            mode_sh    <= 1'b0;
            freq_sh    <= '0;
            settle_sh  <= '0;
            amp_sh_1   <= '0;
            amp_sh_2   <= '0;
            amp_sh_3   <= '0;
        end else begin
            st_q       <= st_nxt;
            prev_q     <= st_q;
            o_stepTrig <= i_en && (st_q != ST_IDLE) && (st_q != prev_q);
            if (st_nxt == ST_IDLE) begin
                o_mod_out <= '0;
                o_state   <= 2'd0;
                dwell_q   <= '0;
                elapsed_q <= '0;
            end else if (step) begin
                o_mod_out <= lvl_nxt;
                o_state   <= idx_nxt;
                elapsed_q <= '0;
                if (st_nxt == ST_S0) begin
                    dwell_q   <= i_freq_cnt;
                    mode_sh   <= i_mode;
                    freq_sh   <= i_freq_cnt;
                    settle_sh <= i_settle;
                    amp_sh_1  <= i_amp_1;
                    amp_sh_2  <= i_amp_2;
                    amp_sh_3  <= i_amp_3;
                end else begin
                    dwell_q <= freq_sh;
                end
            end else begin
                dwell_q <= dwell_q - 32'd1;
                if (elapsed_q != '1) elapsed_q <= elapsed_q + SETTLE_BIT'(1);
            end
        end
    end

    assign o_status       = o_state[0];
    assign o_sample_valid = (st_q != ST_IDLE) && (elapsed_q >= settle_sh);
    assign o_period_end   = dwell_done && ((st_q == ST_S1 && !mode_sh) || st_q == ST_S3);

endmodule

// File: tb/tb_fog_mod_gen_ms.sv
// Directed bench for fog_mod_gen_ms: hand-computed levels, flags and pulses per cycle.
module tb_fog_mod_gen_ms;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic [31:0]        freq_cnt;
    logic [15:0]        settle;
    logic signed [31:0] amp_0, amp_1, amp_2, amp_3;
    logic signed [31:0] mod_out;
    logic [1:0]         state;
    logic               status, step_trig, sample_valid, period_end;

    int errors = 0;
    int checks = 0;

    fog_mod_gen_ms dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .i_mode         (mode),
        .i_freq_cnt     (freq_cnt),
        .i_settle       (settle),
        .i_amp_0        (amp_0),
        .i_amp_1        (amp_1),
        .i_amp_2        (amp_2),
        .i_amp_3        (amp_3),
        .o_mod_out      (mod_out),
        .o_state        (state),
        .o_status       (status),
        .o_stepTrig     (step_trig),
        .o_sample_valid (sample_valid),
        .o_period_end   (period_end)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int st, input bit tr,
                           input bit sv, input bit pe);
        logic [1:0] st2;
        st2 = st[1:0];
        chk({tag, ".mod"},    mod_out,      m);
        chk({tag, ".state"},  {30'd0, state}, {30'd0, st2});
        chk({tag, ".status"}, {31'd0, status}, {31'd0, st2[0]});
        chk({tag, ".trig"},   {31'd0, step_trig}, {31'd0, tr});
        chk({tag, ".sv"},     {31'd0, sample_valid}, {31'd0, sv});
        chk({tag, ".pe"},     {31'd0, period_end}, {31'd0, pe});
    endtask

    task automatic restart(input bit md, input int fc, input int st, input int a0,
                           input int a1, input int a2, input int a3);
        en = 1'b0;
        tick();
        mode = md; freq_cnt = fc; settle = st[15:0];
        amp_0 = a0; amp_1 = a1; amp_2 = a2; amp_3 = a3;
        en = 1'b1;
        tick();
    endtask

    int m3  [14] = '{-100, -100, -100, -100, 100, 100, 100, 100, -100, -100, 50, 50, -100, -100};
    int s3  [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
    bit t3  [14] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    bit v3  [14] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    bit p3  [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int amp4 [4] = '{10, 20, -10, -20};

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; freq_cnt = '0; settle = '0;
        amp_0 = '0; amp_1 = '0; amp_2 = '0; amp_3 = '0;
        repeat (2) tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0);

        // 2-state run: 4-cycle dwells, settle 1
        restart(1'b0, 3, 1, -100, 100, 0, 0);
        for (int c = 0; c < 16; c++) begin
            chk_all("two_state", ((c / 4) % 2) ? 100 : -100, (c / 4) % 2,
                    (c % 4) == 1, (c % 4) >= 1, (c % 8) == 7);
            tick();
        end

        // 4-state run: 10-cycle dwells, 40-cycle period
        restart(1'b1, 9, 0, 10, 20, -10, -20);
        for (int c = 0; c < 80; c++) begin
            chk_all("four_state", amp4[(c / 10) % 4], (c / 10) % 4,
                    (c % 10) == 1, 1'b1, (c % 40) == 39);
            tick();
        end

        // Shadowing: mid-S1 changes land only at the next S0 entry
        restart(1'b0, 3, 1, -100, 100, 0, 0);
        for (int c = 0; c < 14; c++) begin
            if (c == 5) begin
                amp_1 = 50;
                freq_cnt = 1;
            end
            chk_all("shadow", m3[c], s3[c], t3[c], v3[c], p3[c]);
            tick();
        end

        // Settle boundaries with 4-cycle dwells
        restart(1'b0, 3, 0, -100, 100, 0, 0);
        for (int c = 0; c < 8; c++) begin
            chk("settle0.sv", {31'd0, sample_valid}, 32'd1);
            tick();
        end
        restart(1'b0, 3, 3, -100, 100, 0, 0);
        for (int c = 0; c < 8; c++) begin
            chk("settle3.sv", {31'd0, sample_valid}, {31'd0, (c % 4) == 3});
            tick();
        end
        restart(1'b0, 3, 4, -100, 100, 0, 0);
        for (int c = 0; c < 8; c++) begin
            chk("settle4.sv", {31'd0, sample_valid}, 32'd0);
            tick();
        end

        // Disable mid-S2, then re-enable
        restart(1'b1, 9, 0, 10, 20, -10, -20);
        repeat (20) tick();
        chk_all("s2_entry", -10, 2, 0, 1, 0);
        tick();
        chk_all("s2_trig", -10, 2, 1, 1, 0);
        repeat (3) tick();
        en = 1'b0;
        tick();
        chk_all("disabled", 0, 0, 0, 0, 0);
        en = 1'b1;
        tick();
        chk_all("reen_s0", 10, 0, 0, 1, 0);
        tick();
        chk_all("reen_trig", 10, 0, 1, 1, 0);

        // Async reset mid-S1 with 1-cycle dwells in 4-state
        restart(1'b1, 0, 0, 10, 20, -10, -20);
        chk_all("fast_s0", 10, 0, 0, 1, 0);
        tick();
        chk_all("fast_s1", 20, 1, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        tick();
        chk_all("post_s0", 10, 0, 0, 1, 0);
        tick();
        chk_all("post_s1", 20, 1, 1, 1, 0);
        tick();
        chk_all("post_s2", -10, 2, 1, 1, 0);
        tick();
        chk_all("post_s3", -20, 3, 1, 1, 1);
        tick();
        chk_all("post_wrap", 10, 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
